// File: rtl/skew_feeder.sv
// skew_feeder: re-times DIM-lane beats into a diagonal skew (lane k delayed k advances) for systolic FIFOs.
// Optional: define SKEW_FEEDER_SQUARE_CHECK_EN to add a beat counter and a sticky non-square `err` output.
module skew_feeder #(
    parameter int DIM  = 8,
    parameter int BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DIM*BITS-1:0] in_data,
    input  logic                in_last,
    input  logic                out_stall,
    output logic                out_en,
    output logic [DIM*BITS-1:0] out_data,
    output logic                busy,
    output logic                done
`ifdef SKEW_FEEDER_SQUARE_CHECK_EN
    ,
    output logic                err
`endif
);
    localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                accept, adv;
    logic [DIM*BITS-1:0] lane_in, tap, out_data_q, out_data_d;
    logic                out_en_q, out_en_d;

    // state register and flush counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // next state: last beat starts the zero flush, the flush advance from 1 to 0 ends the matrix
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, STREAM: begin
                if (accept) begin
                    state_d = in_last ? ((DIM == 1) ? DONE : FLUSH) : STREAM;
                    cnt_d   = in_last ? CW'(DIM - 1) : cnt_q;
                end
            end
            FLUSH: begin
                if (!out_stall) begin
                    cnt_d   = cnt_q - CW'(1);
                    state_d = (cnt_q == CW'(1)) ? DONE : FLUSH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // outputs decoded from the state
    always_comb begin
        in_ready = (state_q == IDLE || state_q == STREAM) && !out_stall;
        busy     = (state_q == STREAM) || (state_q == FLUSH);
        done     = (state_q == DONE);
    end

    assign accept  = in_valid & in_ready;
    assign adv     = accept | ((state_q == FLUSH) & !out_stall);
    assign lane_in = accept ? in_data : '0;

    for (genvar k = 0; k < DIM; k++) begin : g_lane
        if (k == 0) begin : g_head
            assign tap[BITS-1:0] = lane_in[BITS-1:0];
        end else begin : g_chain
            logic [k*BITS-1:0] sh_q, sh_d;
            // k-deep chain: newest element enters at the bottom, oldest leaves from the top
            always_comb begin
                sh_d = adv ? ((sh_q << BITS) | (k*BITS)'(lane_in[k*BITS +: BITS])) : sh_q;
            end
            // chain storage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) sh_q <= '0;
                else        sh_q <= sh_d;
            end
            assign tap[k*BITS +: BITS] = sh_q[k*BITS-1 -: BITS];
        end
    end

    // output register loads the chain taps on every advance; out_en marks fresh data
    always_comb begin
        out_data_d = adv ? tap : out_data_q;
        out_en_d   = adv;
    end

    // output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q <= '0;
            out_en_q   <= 1'b0;
        end else begin
            out_data_q <= out_data_d;
            out_en_q   <= out_en_d;
        end
    end

    assign out_data = out_data_q;
    assign out_en   = out_en_q;

`ifdef SKEW_FEEDER_SQUARE_CHECK_EN
    localparam int BW = $clog2(DIM + 1);

    logic [BW-1:0] beats_q, beats_d, beats_inc;
    logic          err_q, err_d;

    // count beats of the current matrix; flag a last beat that does not make it square
    always_comb begin
        beats_inc = (state_q == IDLE) ? BW'(1) : ((&beats_q) ? beats_q : beats_q + BW'(1));
        beats_d   = accept ? beats_inc : beats_q;
        err_d     = !accept ? err_q
                  : in_last ? (beats_inc != BW'(DIM))
                  : (state_q == IDLE) ? 1'b0 : err_q;
    end

    // beat counter and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats_q <= '0;
            err_q   <= 1'b0;
        end else begin
            beats_q <= beats_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;
`endif
endmodule
